// File: rtl/fw_ram_guarded_if.sv
// Bus interface of the guarded firmware RAM.
// Carries one access at a time: the master raises cs with we/address/
// write_data and holds them until ready pulses; read_data is meaningful
// only while ready = 1.
//   cs          master -> slave  access request
//   we          master -> slave  byte write enables, 0 = read
//   address     master -> slave  word address
//   write_data  master -> slave  write data
//   read_data   slave -> master  read data, 0 when ready = 0
//   ready       slave -> master  one-cycle completion pulse
interface fw_ram_if #(
    parameter int ADDR_WIDTH = 9
);
    logic                  cs;
    logic [3:0]            we;
    logic [ADDR_WIDTH-1:0] address;
    logic [31:0]           write_data;
    logic [31:0]           read_data;
    logic                  ready;

    modport master (
        output cs, we, address, write_data,
        input  read_data, ready
    );

    modport slave (
        input  cs, we, address, write_data,
        output read_data, ready
    );
endinterface

// File: rtl/fw_ram_guarded.sv
// Multi-bank firmware RAM with mode-based access control, hardware
// zeroisation and sticky violation reporting.
//
// state      | meaning
// -----------+---------------------------------------------------------
// CTRL_CLEAR | clear counter writes zero to every word, one per cycle;
//            | bus requests are stalled, triggers are ignored
// CTRL_IDLE  | normal service; firmware mode reads/writes, application
//            | mode gets ready with zero data and sets violation
//
// Ports:
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   fw_app_mode  0 = firmware mode, 1 = application mode
//   zeroize      single-cycle wipe request
//   bus          slave side of fw_ram_if (cs/we/address/write_data in,
//                read_data/ready out)
//   busy         high while the memory is being cleared
//   violation    sticky: an access was attempted in application mode
module fw_ram_guarded #(
    parameter int ADDR_WIDTH = 9,
    parameter int BANK_AW    = 8
) (
    input  logic    clk,
    input  logic    reset_n,
    input  logic    fw_app_mode,
    input  logic    zeroize,
    fw_ram_if.slave bus,
    output logic    busy,
    output logic    violation
);
    localparam int BANK_BITS = ADDR_WIDTH - BANK_AW;
    localparam int NUM_BANKS = 1 << BANK_BITS;
    // keep the bank index at least one bit wide so a single-bank build elaborates
    localparam int BIDX_W    = (BANK_BITS > 0) ? BANK_BITS : 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    typedef enum logic {CTRL_CLEAR, CTRL_IDLE} ctrl_state_t;

    ctrl_state_t           state;
    logic [ADDR_WIDTH-1:0] clr_cnt;
    logic                  mode_q;
    logic                  ready_q;
    logic                  rd_ok_q;
    logic [BIDX_W-1:0]     bank_sel_q;

    logic                  trig;
    logic                  take;
    logic                  fw_take;

    logic                  ram_en;
    logic [3:0]            ram_be;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [31:0]           ram_wd;
    logic [BIDX_W-1:0]     ram_bank;
    logic [BANK_AW-1:0]    ram_off;
    logic [31:0]           bank_q [NUM_BANKS];

    assign trig    = zeroize | (fw_app_mode & ~mode_q);
    // a request is not re-sampled in the cycle its ready pulse is shown,
    // and a clear trigger in the same cycle takes priority over it
    assign take    = (state == CTRL_IDLE) & bus.cs & ~ready_q & ~trig;
    assign fw_take = take & ~fw_app_mode;

    always_comb begin
        ram_en   = fw_take;
        ram_be   = bus.we;
        ram_addr = bus.address;
        ram_wd   = bus.write_data;
        if (state == CTRL_CLEAR) begin
            ram_en   = 1'b1;
            ram_be   = 4'hF;
            ram_addr = clr_cnt;
            ram_wd   = 32'h0;
        end
    end

    assign ram_bank = BIDX_W'(ram_addr >> BANK_AW);
    assign ram_off  = ram_addr[BANK_AW-1:0];

    // each bank is a low and a high 256x16 halfword array, one per block RAM
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [15:0] mem_lo [2**BANK_AW];
        logic [15:0] mem_hi [2**BANK_AW];
        logic [31:0] q;
        logic        sel;

        assign sel = ram_en & (ram_bank == BIDX_W'(b));

        always_ff @(posedge clk) begin
            if (sel) begin
                if (ram_be[0]) mem_lo[ram_off][7:0]  <= ram_wd[7:0];
                if (ram_be[1]) mem_lo[ram_off][15:8] <= ram_wd[15:8];
                if (ram_be[2]) mem_hi[ram_off][7:0]  <= ram_wd[23:16];
                if (ram_be[3]) mem_hi[ram_off][15:8] <= ram_wd[31:24];
                q <= {mem_hi[ram_off], mem_lo[ram_off]};
            end
        end

        assign bank_q[b] = q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= CTRL_CLEAR;
            clr_cnt    <= '0;
            mode_q     <= 1'b0;
            ready_q    <= 1'b0;
            rd_ok_q    <= 1'b0;
            bank_sel_q <= '0;
            violation  <= 1'b0;
        end else begin
            mode_q  <= fw_app_mode;
            ready_q <= take;
            rd_ok_q <= fw_take & (bus.we == 4'h0);
            if (fw_take) bank_sel_q <= BIDX_W'(bus.address >> BANK_AW);
            if (take & fw_app_mode) violation <= 1'b1;
            case (state)
                CTRL_CLEAR: begin
                    clr_cnt <= clr_cnt + ADDR_WIDTH'(1);
                    if (clr_cnt == LAST_ADDR) state <= CTRL_IDLE;
                end
                default: begin
                    if (trig) begin
                        state   <= CTRL_CLEAR;
                        clr_cnt <= '0;
                    end
                end
            endcase
        end
    end

    assign busy          = (state == CTRL_CLEAR);
    assign bus.ready     = ready_q;
    assign bus.read_data = (ready_q & rd_ok_q) ? bank_q[bank_sel_q] : 32'h0;
endmodule

// File: tb/tb_fw_ram_guarded.sv
module tb_fw_ram_guarded;
    localparam int DEPTH9  = 512;
    localparam int DEPTH10 = 1024;

    logic clk;
    logic reset_n;
    logic mode9, zeroize9, busy9, viol9;
    logic mode10, zeroize10, busy10, viol10;

    int n_cmp = 0;
    int n_err = 0;

    fw_ram_if #(.ADDR_WIDTH(9))  bus9 ();
    fw_ram_if #(.ADDR_WIDTH(10)) bus10 ();

    fw_ram_guarded #(.ADDR_WIDTH(9), .BANK_AW(8)) dut9 (
        .clk(clk), .reset_n(reset_n), .fw_app_mode(mode9), .zeroize(zeroize9),
        .bus(bus9), .busy(busy9), .violation(viol9)
    );

    fw_ram_guarded #(.ADDR_WIDTH(10), .BANK_AW(8)) dut10 (
        .clk(clk), .reset_n(reset_n), .fw_app_mode(mode10), .zeroize(zeroize10),
        .bus(bus10), .busy(busy10), .violation(viol10)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model of the 512-word instance ----------------
    // Memory is an array of words; a clear is "busy for DEPTH cycles, memory reads
    // as zero afterwards"; an accepted request completes one cycle later.
    logic [31:0] m_mem [DEPTH9];
    int          m_left     = DEPTH9;
    bit          m_rdy      = 1'b0;
    bit          m_rd_valid = 1'b0;
    bit          m_viol     = 1'b0;
    bit          m_prev     = 1'b0;
    logic [31:0] m_rd       = 32'h0;

    always @(posedge clk or negedge reset_n) begin : model
        bit was_rdy;
        if (!reset_n) begin
            m_left     = DEPTH9;
            m_rdy      = 1'b0;
            m_rd_valid = 1'b0;
            m_viol     = 1'b0;
            m_prev     = 1'b0;
            for (int i = 0; i < DEPTH9; i++) m_mem[i] = 32'h0;
        end else begin
            was_rdy    = m_rdy;
            m_rdy      = 1'b0;
            m_rd_valid = 1'b0;
            if (m_left > 0) begin
                m_left--;
            end else if (zeroize9 || (mode9 && !m_prev)) begin
                m_left = DEPTH9;
                for (int i = 0; i < DEPTH9; i++) m_mem[i] = 32'h0;
            end else if (bus9.cs && !was_rdy) begin
                m_rdy = 1'b1;
                if (mode9) begin
                    m_viol     = 1'b1;
                    m_rd       = 32'h0;
                    m_rd_valid = 1'b1;
                end else if (bus9.we == 4'h0) begin
                    m_rd       = m_mem[bus9.address];
                    m_rd_valid = 1'b1;
                end else begin
                    for (int b = 0; b < 4; b++)
                        if (bus9.we[b]) m_mem[bus9.address][8*b +: 8] = bus9.write_data[8*b +: 8];
                end
            end
            m_prev = mode9;
        end
    end

    always @(negedge clk) begin
        check("busy", 32'(busy9), 32'(m_left > 0));
        check("ready", 32'(bus9.ready), 32'(m_rdy));
        check("violation", 32'(viol9), 32'(m_viol));
        if (!m_rdy) check("read_data_idle", bus9.read_data, 32'h0);
        else if (m_rd_valid) check("read_data", bus9.read_data, m_rd);
    end

    // ---------------- directed helpers ----------------
    task automatic acc9(input logic [8:0] a, input logic [3:0] w, input logic [31:0] d,
                        output logic [31:0] rd, output int lat);
        @(negedge clk);
        bus9.cs = 1'b1; bus9.we = w; bus9.address = a; bus9.write_data = d;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!bus9.ready && lat < 3000);
        check("acc9_ready", 32'(bus9.ready), 32'h1);
        rd = bus9.read_data;
        bus9.cs = 1'b0; bus9.we = 4'h0;
    endtask

    task automatic acc10(input logic [9:0] a, input logic [3:0] w, input logic [31:0] d,
                         output logic [31:0] rd);
        int lat;
        @(negedge clk);
        bus10.cs = 1'b1; bus10.we = w; bus10.address = a; bus10.write_data = d;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!bus10.ready && lat < 3000);
        check("acc10_ready", 32'(bus10.ready), 32'h1);
        check("acc10_latency", 32'(lat), 32'd1);
        rd = bus10.read_data;
        bus10.cs = 1'b0; bus10.we = 4'h0;
    endtask

    task automatic count_busy9(output int n);
        int g;
        g = 0;
        n = 0;
        while (!busy9 && g < 8) begin @(negedge clk); g++; end
        while (busy9 && g < 5000) begin n++; @(negedge clk); g++; end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] rd;
        int lat, n, cyc;
        logic [31:0] vals [4];

        reset_n = 1'b0; mode9 = 1'b0; zeroize9 = 1'b0; mode10 = 1'b0; zeroize10 = 1'b0;
        bus9.cs = 1'b1; bus9.we = 4'h0; bus9.address = 9'h1FF; bus9.write_data = 32'h0;
        bus10.cs = 1'b0; bus10.we = 4'h0; bus10.address = 10'h0; bus10.write_data = 32'h0;
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(busy9), 32'h1);
        check("reset_ready", 32'(bus9.ready), 32'h0);
        check("reset_violation", 32'(viol9), 32'h0);

        // cs held from the first cycle out of reset: read of the last word
        reset_n = 1'b1;
        n = 0; cyc = 0;
        while (!bus9.ready && cyc < 3000) begin
            if (busy9) n++;
            @(negedge clk);
            cyc++;
        end
        check("reset_clear_cycles", 32'(n), 32'd512);
        check("reset_ready_cycle", 32'(cyc), 32'd513);
        check("reset_read_1ff", bus9.read_data, 32'h0);
        bus9.cs = 1'b0;

        // bank decode
        acc9(9'h005, 4'hF, 32'hDEADBEEF, rd, lat);
        check("wr_005_latency", 32'(lat), 32'd1);
        acc9(9'h105, 4'hF, 32'hCAFEF00D, rd, lat);
        acc9(9'h005, 4'h0, 32'h0, rd, lat);
        check("rd_005", rd, 32'hDEADBEEF);
        check("rd_005_latency", 32'(lat), 32'd1);
        acc9(9'h105, 4'h0, 32'h0, rd, lat);
        check("rd_105", rd, 32'hCAFEF00D);

        // byte masks
        acc9(9'h010, 4'hF, 32'h11223344, rd, lat);
        acc9(9'h010, 4'b0100, 32'hAABBCCDD, rd, lat);
        acc9(9'h010, 4'h0, 32'h0, rd, lat);
        check("rd_010_bytemask", rd, 32'h11BB3344);

        // cs held high: one completion every two cycles
        @(negedge clk);
        bus9.cs = 1'b1; bus9.we = 4'h0; bus9.address = 9'h010;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus9.ready) n++;
        end
        bus9.cs = 1'b0;
        check("back_to_back_pulses", 32'(n), 32'd3);

        // fill, then enter application mode
        for (int i = 0; i < DEPTH9; i++) acc9(i[8:0], 4'hF, 32'hFFFFFFFF, rd, lat);
        acc9(9'h080, 4'h0, 32'h0, rd, lat);
        check("rd_080_filled", rd, 32'hFFFFFFFF);
        @(negedge clk);
        mode9 = 1'b1;
        count_busy9(n);
        check("app_entry_clear_cycles", 32'(n), 32'd512);
        acc9(9'h080, 4'h0, 32'h0, rd, lat);
        check("app_read_zero", rd, 32'h0);
        check("app_read_latency", 32'(lat), 32'd1);
        check("app_violation_set", 32'(viol9), 32'h1);
        acc9(9'h081, 4'hF, 32'h00000055, rd, lat);
        @(negedge clk);
        mode9 = 1'b0;
        acc9(9'h080, 4'h0, 32'h0, rd, lat);
        check("fw_read_080_cleared", rd, 32'h0);
        acc9(9'h081, 4'h0, 32'h0, rd, lat);
        check("app_write_dropped", rd, 32'h0);
        check("violation_sticky", 32'(viol9), 32'h1);

        // zeroize coincident with a write, plus a second zeroize mid-clear
        @(negedge clk);
        zeroize9 = 1'b1;
        bus9.cs = 1'b1; bus9.we = 4'hF; bus9.address = 9'h020; bus9.write_data = 32'h12345678;
        @(negedge clk);
        zeroize9 = 1'b0;
        n = 0; cyc = 0;
        while (busy9 && cyc < 5000) begin
            n++;
            zeroize9 = (n == 200);
            @(negedge clk);
            cyc++;
        end
        zeroize9 = 1'b0;
        check("zeroize_clear_cycles", 32'(n), 32'd512);
        cyc = 0;
        while (!bus9.ready && cyc < 10) begin @(negedge clk); cyc++; end
        check("stalled_write_ready_delay", 32'(cyc), 32'd1);
        bus9.cs = 1'b0; bus9.we = 4'h0;
        acc9(9'h020, 4'h0, 32'h0, rd, lat);
        check("rd_020_after_clear", rd, 32'h12345678);

        // mode edge and zeroize together: one pass; app->fw edge does nothing
        @(negedge clk);
        mode9 = 1'b1; zeroize9 = 1'b1;
        @(negedge clk);
        zeroize9 = 1'b0;
        count_busy9(n);
        check("dual_trigger_clear_cycles", 32'(n), 32'd512);
        mode9 = 1'b0;
        repeat (3) @(negedge clk);
        check("fw_edge_no_clear", 32'(busy9), 32'h0);

        // 4-bank instance
        @(negedge clk);
        zeroize10 = 1'b1;
        @(negedge clk);
        zeroize10 = 1'b0;
        n = 0; cyc = 0;
        while (busy10 && cyc < 5000) begin n++; @(negedge clk); cyc++; end
        check("aw10_clear_cycles", 32'(n), 32'd1024);
        vals[0] = 32'hA0A0_0001; vals[1] = 32'hB1B1_0102;
        vals[2] = 32'hC2C2_0203; vals[3] = 32'hD3D3_0304;
        for (int i = 0; i < 4; i++) acc10(10'((i << 8) | 8'hFF), 4'hF, vals[i], rd);
        for (int i = 0; i < 4; i++) begin
            acc10(10'((i << 8) | 8'hFF), 4'h0, 32'h0, rd);
            check("aw10_bank_readback", rd, vals[i]);
        end
        check("aw10_violation_clear", 32'(viol10), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
